// File: rtl/deser_pkg.sv
// Shared types and line-level constants for the bit-serial frame receiver.
package deser_pkg;

  // Receiver frame position; the 2-bit encoding is fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_t;

  // Line levels that open and close a frame.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : deser_pkg

// File: rtl/deser_frame_rx_parity_tree.sv
// XOR reduction of a data word, built as a chain of gate_xor primitives.
module parity_tree #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  output logic             p
);

  // chain[i] holds the XOR of d[0] through d[i].
  logic chain [WIDTH];

  assign chain[0] = d[0];

  for (genvar i = 1; i < WIDTH; i++) begin : g_stage
    gate_xor u_xor (
      .a (chain[i-1]),
      .b (d[i]),
      .y (chain[i])
    );
  end

  assign p = chain[WIDTH-1];

endmodule : parity_tree

// File: rtl/gate_xor.sv
// Library two-input XOR primitive.
module gate_xor (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule : gate_xor

// File: rtl/deser_frame_rx.sv
// Serial-to-parallel frame receiver: start, WIDTH data bits LSB first,
// optional parity, stop. Good words land in a one-entry valid/ready buffer.
module deser_frame_rx
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  input  logic             err_clr
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;
  logic             data_xor;
  logic             par_calc;

  parity_tree #(.WIDTH(WIDTH)) u_parity (
    .d (shreg),
    .p (data_xor)
  );

  // Expected parity bit for the word currently in the shift register.
  assign par_calc = data_xor ^ 1'(PARITY_ODD);

  // Frame FSM, shift register, output buffer and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // NOTE: later non-blocking assignments to the same register win, so the
      // consume-clear here is overridden by a same-edge load below, and
      // err_clr at the bottom overrides any flag set in STOP.
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end

      if (sin_valid) begin
        unique case (state)
          IDLE: begin
            if (sin == START_BIT) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg[cnt] <= sin;
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= (PARITY_EN != 0) ? PAR : STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PAR: begin
            par_bit <= sin;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if ((PARITY_EN != 0) && (par_calc != par_bit)) begin
              parity_err <= 1'b1;
            end
            if (sin != STOP_BIT) begin
              frame_err <= 1'b1;
            end else if (!dout_valid || dout_ready) begin
              dout       <= shreg;
              dout_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      if (err_clr) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule : deser_frame_rx

// File: tb/tb_deser_frame_rx.sv
// Directed bench for deser_frame_rx (WIDTH=8, even parity).
module tb_deser_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  deser_frame_rx #(.WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_valid;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; presents one strobe, then idles for gap cycles.
  task automatic send_bit(input logic b, input int gap);
    sin       = b;
    sin_valid = 1'b1;
    @(negedge clk);
    sin_valid = 1'b0;
    sin       = $urandom_range(0, 1);
    repeat (gap) @(negedge clk);
  endtask

  // Start, data LSB first, parity; stop strobe has no trailing gap so the
  // caller samples the result on the very next negedge.
  task automatic send_head(input logic [7:0] d, input logic p, input int max_gap);
    send_bit(1'b0, $urandom_range(0, max_gap));
    for (int i = 0; i < 8; i++) send_bit(d[i], $urandom_range(0, max_gap));
    send_bit(p, $urandom_range(0, max_gap));
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int max_gap);
    send_head(d, p, max_gap);
    send_bit(s, 0);
  endtask

  task automatic check_flags(input string tag, input logic pe, input logic fe, input logic ov);
    check({tag, ".parity_err"}, 32'(parity_err), 32'(pe));
    check({tag, ".frame_err"},  32'(frame_err),  32'(fe));
    check({tag, ".overrun"},    32'(overrun),    32'(ov));
  endtask

  task automatic clear_all();
    dout_ready = 1'b1;
    err_clr    = 1'b1;
    @(negedge clk);
    err_clr    = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0}; // clean frame
    vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0}; // bad parity, still delivered
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1}; // bad stop, dout unchanged
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; sin = 1'b1; sin_valid = 1'b0; dout_ready = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.dout", 32'(dout), 32'h0);
    check("reset.dout_valid", 32'(dout_valid), 32'h0);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    send_bit(1'b1, 1); // line idle, must not start a frame

    // Table-driven frames with ready held high.
    foreach (vecs[k]) begin
      dout_ready = 1'b1;
      send_frame(vecs[k].data, vecs[k].par, vecs[k].stop, 2);
      check($sformatf("vec%0d.dout", k), 32'(dout), 32'(vecs[k].exp_dout));
      check($sformatf("vec%0d.dout_valid", k), 32'(dout_valid), 32'(vecs[k].exp_valid));
      check_flags($sformatf("vec%0d", k), vecs[k].exp_perr, vecs[k].exp_ferr, 1'b0);
      clear_all();
      check($sformatf("vec%0d.post_valid", k), 32'(dout_valid), 32'h0);
      check_flags($sformatf("vec%0d.post", k), 1'b0, 1'b0, 1'b0);
    end

    // Overrun: second word dropped while the first is unconsumed.
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 3);
    check("ovr.first_dout", 32'(dout), 32'h11);
    check("ovr.first_valid", 32'(dout_valid), 32'h1);
    send_frame(8'h22, 1'b0, 1'b1, 3);
    check("ovr.held_dout", 32'(dout), 32'h11);
    check("ovr.held_valid", 32'(dout_valid), 32'h1);
    check_flags("ovr", 1'b0, 1'b0, 1'b1);
    dout_ready = 1'b1;
    @(negedge clk);
    check("ovr.drained_valid", 32'(dout_valid), 32'h0);
    check("ovr.sticky", 32'(overrun), 32'h1);
    clear_all();
    check("ovr.cleared", 32'(overrun), 32'h0);

    // Transfer and load on the same edge keep dout_valid high with new data.
    dout_ready = 1'b0;
    send_frame(8'h0F, 1'b0, 1'b1, 2);
    send_head(8'hF0, 1'b0, 2);
    dout_ready = 1'b1;
    send_bit(1'b1, 0);
    check("swap.dout", 32'(dout), 32'hF0);
    check("swap.dout_valid", 32'(dout_valid), 32'h1);
    check("swap.overrun", 32'(overrun), 32'h0);
    clear_all();

    // err_clr on the stop strobe wins over the parity set.
    send_head(8'h01, 1'b0, 1);
    err_clr = 1'b1;
    send_bit(1'b1, 0);
    err_clr = 1'b0;
    check("clrprio.parity_err", 32'(parity_err), 32'h0);
    check("clrprio.dout", 32'(dout), 32'h01);
    clear_all();

    // Back-to-back frames, random gaps, no idle bit between frames.
    dout_ready = 1'b1;
    send_frame(8'h55, 1'b0, 1'b1, 3);
    check("b2b.first", 32'(dout), 32'h55);
    check("b2b.first_valid", 32'(dout_valid), 32'h1);
    send_frame(8'hAA, 1'b0, 1'b1, 3);
    check("b2b.second", 32'(dout), 32'hAA);
    check("b2b.second_valid", 32'(dout_valid), 32'h1);
    check_flags("b2b", 1'b0, 1'b0, 1'b0);
    clear_all();

    // Reset in the middle of a frame aborts it.
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.dout", 32'(dout), 32'h0);
    check("midrst.dout_valid", 32'(dout_valid), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst.after_valid", 32'(dout_valid), 32'h0);
    send_frame(8'h7E, 1'b0, 1'b1, 2);
    check("midrst.dout_7e", 32'(dout), 32'h7E);
    check("midrst.valid_7e", 32'(dout_valid), 32'h1);
    check_flags("midrst", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_deser_frame_rx
